// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: decodes HD44780-style 8-bit bus writes into a 2x16 character mirror and checks bus timing
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_lcd_data/rs/rw/en       : LCD bus, synchronous to i_clk; a transfer is taken on the enable fall
//   i_clr_err                 : synchronous clear of the sticky error flags
//   i_rd_addr / o_rd_char     : mirror read port (0-15 line 1, 16-31 line 2), 1-cycle latency
//   o_ddram_addr              : DDRAM address counter
//   o_display_on/cursor_on/blink_on/two_line : display control and function set state
//   o_busy                    : emulated panel busy time
//   o_wr_strobe/o_cmd_strobe  : 1-cycle pulse per accepted data write / command
//   o_err_timing/unsup/read   : sticky error flags
module lcd_bus_receiver #(
    parameter int CMD_CYCLES   = 1850,
    parameter int CLEAR_CYCLES = 76000,
    parameter int MIN_EN_HIGH  = 12
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_lcd_data,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_en,
    input  logic       i_clr_err,
    input  logic [4:0] i_rd_addr,
    output logic [7:0] o_rd_char,
    output logic [6:0] o_ddram_addr,
    output logic       o_display_on,
    output logic       o_cursor_on,
    output logic       o_blink_on,
    output logic       o_two_line,
    output logic       o_busy,
    output logic       o_wr_strobe,
    output logic       o_cmd_strobe,
    output logic       o_err_timing,
    output logic       o_err_unsup,
    output logic       o_err_read
);
    localparam int CW = $clog2(MIN_EN_HIGH + 1);
    localparam logic [CW-1:0] W_MIN = CW'(MIN_EN_HIGH);
    typedef enum logic [1:0] {IDLE, EN_HIGH, EXEC, CLEAR_FILL} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [7:0] r_data, r_rd_char;
    logic r_rs, r_rw, r_en_d, r_inc;
    logic [4:0] r_fill;
    logic [16:0] r_busy_cnt;
    logic [7:0] r_mem [32];
    logic [6:0] r_addr;
    logic r_disp, r_cur, r_blink, r_two, r_wr_stb, r_cmd_stb, r_err_t, r_err_u, r_err_r;
    logic w_fall, w_short, w_accept, w_cmd, w_dat, w_clr, w_home, w_entry, w_dctl, w_shift, w_func, w_cgram;
    logic w_unsup, w_err_t, w_err_r, w_cell_ok;
    logic [6:0] w_addr_nxt;
    logic [4:0] w_cell;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, EXEC: w_next = i_lcd_en ? EN_HIGH : IDLE;
            EN_HIGH:    if (!i_lcd_en) w_next = !w_accept ? IDLE : (w_cmd && w_clr) ? CLEAR_FILL : EXEC;
            CLEAR_FILL: if (r_fill == 5'd31) w_next = i_lcd_en ? EN_HIGH : IDLE;
            default:    w_next = IDLE;
        endcase
    end
    always_comb begin
        w_fall     = (r_state == EN_HIGH) && !i_lcd_en;
        w_short    = r_cnt < W_MIN;
        w_accept   = w_fall && !w_short && !o_busy && !r_rw;
        w_cmd      = w_accept && !r_rs;
        w_dat      = w_accept && r_rs;
        w_clr      = r_data == 8'h01;
        w_home     = r_data[7:1] == 7'h01;
        w_entry    = r_data[7:2] == 6'h01;
        w_dctl     = r_data[7:3] == 5'h01;
        w_shift    = r_data[7:4] == 4'h1;
        w_func     = r_data[7:5] == 3'h1;
        w_cgram    = r_data[7:6] == 2'h1;
        w_unsup    = w_cmd && ((w_entry && r_data[0]) || w_shift || (w_func && !r_data[4]) || w_cgram);
        // a whole enable pulse can also begin and end while the clear fill is running
        w_err_t    = (w_fall && (w_short || o_busy)) || (r_state == CLEAR_FILL && r_en_d && !i_lcd_en);
        w_err_r    = w_fall && !w_short && !o_busy && r_rw;
        w_addr_nxt = r_inc ? (r_addr == 7'h27 ? 7'h40 : r_addr == 7'h67 ? 7'h00 : r_addr + 7'd1)
                           : (r_addr == 7'h00 ? 7'h67 : r_addr == 7'h40 ? 7'h27 : r_addr - 7'd1);
        // 0x00-0x0F and 0x40-0x4F are the only visible cells
        w_cell_ok  = r_addr[5:4] == 2'b00;
        w_cell     = {r_addr[6], r_addr[3:0]};
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= 8'h20;
            r_cnt      <= '0;
            r_data     <= '0;
            r_rs       <= 1'b0;
            r_rw       <= 1'b0;
            r_en_d     <= 1'b0;
            r_fill     <= '0;
            r_busy_cnt <= '0;
            r_inc      <= 1'b1;
            r_addr     <= '0;
            r_disp     <= 1'b0;
            r_cur      <= 1'b0;
            r_blink    <= 1'b0;
            r_two      <= 1'b0;
            r_wr_stb   <= 1'b0;
            r_cmd_stb  <= 1'b0;
            r_err_t    <= 1'b0;
            r_err_u    <= 1'b0;
            r_err_r    <= 1'b0;
            r_rd_char  <= 8'h00;
        end else begin
            if (i_lcd_en) begin
                r_data <= i_lcd_data;
                r_rs   <= i_lcd_rs;
                r_rw   <= i_lcd_rw;
                r_cnt  <= (r_state != EN_HIGH) ? CW'(1) : (r_cnt == W_MIN) ? r_cnt : r_cnt + CW'(1);
            end
            r_en_d     <= i_lcd_en;
            r_busy_cnt <= w_accept ? ((w_cmd && (w_clr || w_home)) ? 17'(CLEAR_CYCLES) : 17'(CMD_CYCLES))
                                   : o_busy ? r_busy_cnt - 17'd1 : r_busy_cnt;
            r_wr_stb   <= w_dat;
            r_cmd_stb  <= w_cmd;
            r_err_t    <= w_err_t || (r_err_t && !i_clr_err);
            r_err_u    <= w_unsup || (r_err_u && !i_clr_err);
            r_err_r    <= w_err_r || (r_err_r && !i_clr_err);
            r_fill     <= (r_state == CLEAR_FILL) ? r_fill + 5'd1 : 5'd0;
            if (r_state == CLEAR_FILL) r_mem[r_fill] <= 8'h20;
            if (w_dat && w_cell_ok) r_mem[w_cell] <= r_data;
            if (w_dat) r_addr <= w_addr_nxt;
            if (w_cmd && (w_clr || w_home)) r_addr <= 7'h00;
            if (w_cmd && w_clr) r_inc <= 1'b1;
            if (w_cmd && w_entry) r_inc <= r_data[1];
            if (w_cmd && w_dctl) {r_disp, r_cur, r_blink} <= r_data[2:0];
            if (w_cmd && w_func) r_two <= r_data[3];
            if (w_cmd && r_data[7]) r_addr <= r_data[6:0];
            r_rd_char <= r_mem[i_rd_addr];
        end
    end
    assign o_busy       = |r_busy_cnt;
    assign o_rd_char    = r_rd_char;
    assign o_ddram_addr = r_addr;
    assign o_display_on = r_disp;
    assign o_cursor_on  = r_cur;
    assign o_blink_on   = r_blink;
    assign o_two_line   = r_two;
    assign o_wr_strobe  = r_wr_stb;
    assign o_cmd_strobe = r_cmd_stb;
    assign o_err_timing = r_err_t;
    assign o_err_unsup  = r_err_u;
    assign o_err_read   = r_err_r;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: table-driven, directed and random checks of lcd_bus_receiver against a behavioural model
module tb_lcd_bus_receiver;
    localparam int CMD  = 60;
    localparam int CLR  = 1200;
    localparam int MINW = 12;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0, clr_err = 1'b0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] ddram_addr;
    logic display_on, cursor_on, blink_on, two_line, busy, wr_strobe, cmd_strobe;
    logic err_timing, err_unsup, err_read;
    lcd_bus_receiver #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR), .MIN_EN_HIGH(MINW)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_lcd_data(lcd_data), .i_lcd_rs(lcd_rs), .i_lcd_rw(lcd_rw),
        .i_lcd_en(lcd_en), .i_clr_err(clr_err), .i_rd_addr(rd_addr), .o_rd_char(rd_char),
        .o_ddram_addr(ddram_addr), .o_display_on(display_on), .o_cursor_on(cursor_on), .o_blink_on(blink_on),
        .o_two_line(two_line), .o_busy(busy), .o_wr_strobe(wr_strobe), .o_cmd_strobe(cmd_strobe),
        .o_err_timing(err_timing), .o_err_unsup(err_unsup), .o_err_read(err_read));
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_chk = 0, n_fail = 0;
    // behavioural model of the panel as seen from the bus
    int m_mem [32];
    int m_addr, busy_end;
    bit m_inc, m_disp, m_cur, m_blink, m_two, m_et, m_eu, m_er;
    typedef struct { bit rs; logic [7:0] d; int addr; bit two; bit disp; } vec_t;
    vec_t tbl [18];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_addr = 0; m_inc = 1; busy_end = 0;
        {m_disp, m_cur, m_blink, m_two, m_et, m_eu, m_er} = '0;
    endtask
    task automatic model_cmd(input int d, input int dc);
        if (d == 1) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_addr = 0; m_inc = 1; busy_end = dc + CLR;
        end else if (d <= 3) begin
            m_addr = 0; busy_end = dc + CLR;
        end else begin
            busy_end = dc + CMD;
            if (d < 8) begin m_inc = d[1]; if (d[0]) m_eu = 1; end
            else if (d < 16) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
            else if (d < 32) m_eu = 1;
            else if (d < 64) begin m_two = d[3]; if (!d[4]) m_eu = 1; end
            else if (d < 128) m_eu = 1;
            else m_addr = d - 128;
        end
    endtask
    task automatic model_data(input int d, input int dc);
        if (m_addr < 16) m_mem[m_addr] = d;
        else if (m_addr >= 64 && m_addr < 80) m_mem[m_addr - 48] = d;
        if (m_inc) m_addr = (m_addr == 39) ? 64 : (m_addr == 103) ? 0 : (m_addr + 1) % 128;
        else m_addr = (m_addr == 0) ? 103 : (m_addr == 64) ? 39 : (m_addr + 127) % 128;
        busy_end = dc + CMD;
    endtask
    // one enable pulse of w clk cycles; checks all visible state in the cycle after the fall
    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input int w, input bit clr);
        int dc;
        bit acc;
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (w) @(negedge clk);
        lcd_en = 1'b0; clr_err = clr;
        dc = cyc + 1;
        @(negedge clk);
        clr_err = 1'b0;
        if (clr) {m_et, m_eu, m_er} = '0;
        acc = 0;
        if (w < MINW || dc - 1 < busy_end) m_et = 1;
        else if (rw) m_er = 1;
        else begin
            acc = 1;
            if (rs) model_data(d, dc); else model_cmd(d, dc);
        end
        chk("cmd_strobe", cmd_strobe, acc && !rs);
        chk("wr_strobe", wr_strobe, acc && rs);
        chk("busy", busy, dc < busy_end);
        chk("ddram_addr", ddram_addr, m_addr);
        chk("disp_ctl", {display_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink});
        chk("two_line", two_line, m_two);
        chk("errors", {err_timing, err_unsup, err_read}, {m_et, m_eu, m_er});
    endtask
    task automatic wait_idle();
        while (cyc < busy_end) @(negedge clk);
    endtask
    task automatic start_at(input int dc, input int w);
        while (cyc < dc - w - 1) @(negedge clk);
    endtask
    task automatic clr_pulse();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        {m_et, m_eu, m_er} = '0;
        chk("errors_cleared", {err_timing, err_unsup, err_read}, 3'b000);
    endtask
    task automatic dump_mirror();
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            chk($sformatf("cell[%0d]", i), rd_char, m_mem[i]);
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int r, w;
        logic [7:0] d;
        tbl[0]  = '{0, 8'h38, 'h00, 1, 0};
        tbl[1]  = '{0, 8'h38, 'h00, 1, 0};
        tbl[2]  = '{0, 8'h0C, 'h00, 1, 1};
        tbl[3]  = '{0, 8'h01, 'h00, 1, 1};
        tbl[4]  = '{0, 8'h06, 'h00, 1, 1};
        tbl[5]  = '{1, 8'h4C, 'h01, 1, 1};
        tbl[6]  = '{1, 8'h4F, 'h02, 1, 1};
        tbl[7]  = '{1, 8'h41, 'h03, 1, 1};
        tbl[8]  = '{1, 8'h44, 'h04, 1, 1};
        tbl[9]  = '{0, 8'hC0, 'h40, 1, 1};
        tbl[10] = '{1, 8'h2B, 'h41, 1, 1};
        tbl[11] = '{0, 8'hA7, 'h27, 1, 1};
        tbl[12] = '{1, 8'h41, 'h40, 1, 1};
        tbl[13] = '{0, 8'hE7, 'h67, 1, 1};
        tbl[14] = '{1, 8'h42, 'h00, 1, 1};
        tbl[15] = '{0, 8'h04, 'h00, 1, 1};
        tbl[16] = '{0, 8'hC0, 'h40, 1, 1};
        tbl[17] = '{1, 8'h43, 'h27, 1, 1};
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ddram_addr, display_on, cursor_on, blink_on, two_line, busy, wr_strobe, cmd_strobe},
            '0);
        chk("reset_errors", {err_timing, err_unsup, err_read}, 3'b000);
        chk("reset_rd_char", rd_char, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            wait_idle();
            xfer(tbl[i].rs, 1'b0, tbl[i].d, 40, 1'b0);
            chk($sformatf("tbl[%0d].addr", i), ddram_addr, tbl[i].addr);
            chk($sformatf("tbl[%0d].two", i), two_line, tbl[i].two);
            chk($sformatf("tbl[%0d].disp", i), display_on, tbl[i].disp);
        end
        wait_idle();
        dump_mirror();
        rd_addr = 5'd0; @(negedge clk); chk("cell0_L", rd_char, 8'h4C);
        rd_addr = 5'd3; @(negedge clk); chk("cell3_D", rd_char, 8'h44);
        rd_addr = 5'd16; @(negedge clk); chk("cell16_C", rd_char, 8'h43);
        // rd_char follows a cell write two cycles after the enable fall
        xfer(1'b0, 1'b0, 8'h85, 20, 1'b0);
        wait_idle();
        rd_addr = 5'd5;
        @(negedge clk);
        xfer(1'b1, 1'b0, 8'h5A, 20, 1'b0);
        chk("rd_char_old", rd_char, 8'h20);
        @(negedge clk);
        chk("rd_char_new", rd_char, 8'h5A);
        // transfer during a Clear busy window is dropped
        wait_idle();
        xfer(1'b0, 1'b0, 8'h01, 40, 1'b0);
        repeat (1000) @(negedge clk);
        xfer(1'b0, 1'b0, 8'h0F, 20, 1'b0);
        chk("busy_viol_err", err_timing, 1'b1);
        chk("busy_viol_ignored", cursor_on, 1'b0);
        clr_pulse();
        // enable width and busy-end boundaries
        wait_idle();
        xfer(1'b0, 1'b0, 8'h0F, MINW - 1, 1'b0);
        chk("short_en_err", err_timing, 1'b1);
        clr_pulse();
        xfer(1'b0, 1'b0, 8'h0E, MINW, 1'b0);
        chk("min_width_ok", cursor_on, 1'b1);
        start_at(busy_end, 15);
        xfer(1'b0, 1'b0, 8'h0C, 15, 1'b0);
        chk("fall_while_busy", err_timing, 1'b1);
        clr_pulse();
        wait_idle();
        xfer(1'b0, 1'b0, 8'h0F, 15, 1'b0);
        start_at(busy_end + 1, 15);
        xfer(1'b0, 1'b0, 8'h0C, 15, 1'b0);
        chk("fall_at_busy_end_ok", {cursor_on, err_timing}, 2'b00);
        // short enable, read attempt, unsupported command
        wait_idle();
        xfer(1'b0, 1'b0, 8'h0F, 5, 1'b0);
        chk("short5_no_change", blink_on, 1'b0);
        xfer(1'b1, 1'b1, 8'h55, 20, 1'b0);
        chk("read_err", err_read, 1'b1);
        wait_idle();
        xfer(1'b0, 1'b0, 8'h18, 20, 1'b0);
        chk("unsup_err", err_unsup, 1'b1);
        // a new error in the clearing cycle survives the clear
        xfer(1'b0, 1'b0, 8'h0F, 4, 1'b1);
        chk("clr_vs_new_err", {err_timing, err_unsup, err_read}, 3'b100);
        clr_pulse();
        // random traffic against the model
        for (int k = 0; k < 150; k++) begin
            wait_idle();
            r = $urandom_range(0, 99);
            w = $urandom_range(MINW, MINW + 8);
            if (r < 55) xfer(1'b1, 1'b0, 8'($urandom_range(8'h20, 8'h7E)), w, $urandom_range(0, 9) == 0);
            else if (r < 70) begin
                d = 8'h80 + ($urandom_range(0, 1) ? 8'h40 : 8'h00) + 8'($urandom_range(0, 39));
                xfer(1'b0, 1'b0, ($urandom_range(0, 4) == 0) ? 8'($urandom_range(8'h80, 8'hFF)) : d, w, 1'b0);
            end
            else if (r < 80) xfer(1'b0, 1'b0, 8'($urandom_range(4, 7)), w, 1'b0);
            else if (r < 88) xfer(1'b0, 1'b0, 8'($urandom_range(8, 15)), w, 1'b0);
            else if (r < 95) xfer(1'b0, 1'b0, 8'($urandom_range(1, 127)), w, 1'b0);
            else if (r < 98) xfer($urandom_range(0, 1) == 1, 1'b0, 8'($urandom), $urandom_range(2, MINW - 1), 1'b0);
            else xfer($urandom_range(0, 1) == 1, 1'b1, 8'($urandom), w, 1'b0);
        end
        wait_idle();
        dump_mirror();
        // reset in the middle of a clear fill
        xfer(1'b1, 1'b0, 8'h58, 20, 1'b0);
        wait_idle();
        xfer(1'b0, 1'b0, 8'h0F, 20, 1'b0);
        wait_idle();
        xfer(1'b0, 1'b0, 8'h01, 20, 1'b0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midclear_reset_state", {ddram_addr, display_on, cursor_on, blink_on, two_line, busy}, '0);
        chk("midclear_reset_rd", rd_char, 8'h00);
        chk("midclear_reset_err", {err_timing, err_unsup, err_read}, 3'b000);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        xfer(1'b0, 1'b0, 8'h0C, 20, 1'b0);
        chk("after_reset_accept", display_on, 1'b1);
        wait_idle();
        dump_mirror();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Receiving end of the HD44780-style 8-bit parallel LCD bus that our LCD controller drives. It watches `lcd_data`/`lcd_rs`/`lcd_rw`/`lcd_en` and decodes each enable pulse as a command or data write. It keeps a 2×16 character mirror of the display and checks bus timing against the panel's busy times. It is used in simulation benches and on-chip to mirror LCD contents to debug logic.

## Interface
- `CMD_CYCLES`, default 1850: busy time after a normal command or data write (37 µs at 50 MHz).
- `CLEAR_CYCLES`, default 76000: busy time after Clear or Return Home (1.52 ms at 50 MHz).
- `MIN_EN_HIGH`, default 12: minimum `lcd_en` high width in clk cycles.
- `clk` in 1: single clock; all bus inputs are synchronous to it.
- `reset_n` in 1: asynchronous, active-low reset.
- `lcd_data` in 8: bus data.
- `lcd_rs` in 1: 0 = command, 1 = data.
- `lcd_rw` in 1: 0 = write, 1 = read.
- `lcd_en` in 1: enable; a transfer is taken on its falling edge.
- `clr_err` in 1: synchronous clear of the sticky error flags.
- `rd_addr` in 5: mirror read index; 0–15 = line 1, 16–31 = line 2.
- `rd_char` out 8: mirror character at `rd_addr`, registered, 1-cycle latency.
- `ddram_addr` out 7: current DDRAM address counter.
- `display_on` out 1: D bit of Display Control.
- `cursor_on` out 1: C bit of Display Control.
- `blink_on` out 1: B bit of Display Control.
- `two_line` out 1: N bit of Function Set.
- `busy` out 1: high while the emulated busy time runs.
- `wr_strobe` out 1: 1-cycle pulse for each accepted data write.
- `cmd_strobe` out 1: 1-cycle pulse for each accepted command.
- `err_timing` out 1: sticky timing-violation flag.
- `err_unsup` out 1: sticky unsupported-command flag.
- `err_read` out 1: sticky read-attempt flag.

## Operation
- **Reset values:**
  - All 32 mirror cells = 0x20.
  - `ddram_addr` = 0; increment mode.
  - `display_on`, `cursor_on`, `blink_on`, `two_line` = 0.
  - `busy` and all strobes = 0; all errors = 0; `rd_char` = 0x00.
  - FSM in IDLE.
- **FSM states:** IDLE, EN_HIGH, EXEC, CLEAR_FILL.
  - IDLE → EN_HIGH on `lcd_en` = 1. EN_HIGH counts high cycles and captures `lcd_data`/`lcd_rs`/`lcd_rw` every cycle.
  - On `lcd_en` falling, the values captured in the last high cycle are used.
  - Width < `MIN_EN_HIGH`: set `err_timing`, ignore the transfer, go to IDLE.
  - `lcd_rw` = 1: set `err_read`, ignore, go to IDLE.
  - Otherwise, in the cycle after the fall: decode, strobe, load the busy counter, then go to EXEC (or CLEAR_FILL for Clear).
- **Falling edge while `busy` = 1:** set `err_timing` and ignore the transfer. The busy counter keeps running.
- **Command decode** (leading one of `lcd_data`):
  - 0x01 Clear: fill cells 0..31 with 0x20, one per cycle (32 cycles, inside busy); `ddram_addr` = 0; increment mode; busy = `CLEAR_CYCLES`.
  - 0x02/0x03 Return Home: `ddram_addr` = 0; busy = `CLEAR_CYCLES`.
  - 0x04–0x07 Entry Mode: bit1 = 1 selects increment, 0 selects decrement. Bit0 (shift) = 1 sets `err_unsup`; mode is still applied.
  - 0x08–0x0F Display Control: bits 2/1/0 → `display_on`/`cursor_on`/`blink_on`.
  - 0x10–0x1F Cursor/Display Shift: `err_unsup`, no state change.
  - 0x20–0x3F Function Set: bit3 → `two_line`. Bit4 (DL) = 0 sets `err_unsup`.
  - 0x40–0x7F Set CGRAM: `err_unsup`, no state change.
  - 0x80–0xFF Set DDRAM: `ddram_addr` = `lcd_data[6:0]`.
  - Every accepted command, unsupported ones included, pulses `cmd_strobe` and uses busy = `CMD_CYCLES`, except Clear and Return Home.
- **Data write:**
  - Address 0x00–0x0F → cell `addr[3:0]`; 0x40–0x4F → cell 16 + `addr[3:0]`; any other address is not stored.
  - Then step the address with HD44780 wrap:
    - Increment: 0x27 → 0x40, 0x67 → 0x00.
    - Decrement: 0x00 → 0x67, 0x40 → 0x27.
    - Out-of-range addresses (0x28–0x3F, 0x68–0x7F) step arithmetically mod 128.
  - Pulse `wr_strobe`; busy = `CMD_CYCLES`.
- **Error flags:** `clr_err` clears all three. A new error in the same cycle as `clr_err` wins (flag ends at 1).
- **Reset mid-operation:** async reset aborts any state, including CLEAR_FILL, and restores the reset values immediately.

## Timing
- Decode and register update happen 1 cycle after the `lcd_en` falling edge. Strobes and `busy` rise in that same cycle.
- `busy` stays high for exactly N cycles (N = `CMD_CYCLES` or `CLEAR_CYCLES`). The next falling edge is legal in the cycle `busy` reads 0.
- CLEAR_FILL finishes 32 cycles after decode; cells not yet filled still read old data. This requires `CLEAR_CYCLES` ≥ 32.
- `rd_char` reflects a cell write 1 cycle after the write cycle; total 2 cycles after the enable fall.
- Busy counter width: 17 bits (covers 76000).

## Test plan
- **Init sequence:** reset, then 0x38, 0x38, 0x0C, 0x01, 0x06, each with a 40-cycle enable and full busy gaps. Expect `two_line` = 1, `display_on` = 1, `cursor_on` = 0, all cells 0x20, `ddram_addr` = 0, no errors.
- **Data write:** write "LOAD" at 0x00. Expect cells 0–3 = 0x4C 0x4F 0x41 0x44, `ddram_addr` = 4, four `wr_strobe` pulses. Then send 0xC0 and write "+" → cell 16 = 0x2B, `ddram_addr` = 0x41.
- **Wrap:**
  - Set 0x27, write 'A' → not stored, addr = 0x40.
  - Set 0x67, write 'B' → addr = 0x00.
  - Entry 0x04 (decrement), set 0x40, write 'C' → cell 16 = 0x43, addr = 0x27.
- **Busy violation:** send 0x01, then a second enable 1000 cycles later. Expect `err_timing` = 1 and the second transfer ignored. Pulse `clr_err` → 0.
- **Short enable and read:** a 5-cycle enable → `err_timing`, no state change. `lcd_rw` = 1 → `err_read`. Command 0x18 → `err_unsup`, `cmd_strobe` pulses.
- **Reset mid-clear:** assert `reset_n` low 10 cycles into CLEAR_FILL. Expect all outputs at reset values; the first transfer after release is accepted.
